fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the byte-addressable memory block. It generates a word-aligned PC stream and drives the memory's read port as single-word reads (access_size 00, rw=1). It captures the returned data, tags each word with its PC, and buffers it in a small FIFO. Instructions are presented to decode over a valid/ready handshake, with redirect (branch/jump) flush support.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's memory read port and its decode-side instruction
// handshake. master = fetch unit; slave = memory/decode side.
interface fetch_unit_if;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic [31:0] mem_data_out;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        fetch_fault;

  modport master (
    output mem_address, mem_access_size, mem_rw, mem_enable,
    output insn_valid, insn, insn_pc, fetch_fault,
    input  mem_data_out, insn_ready
  );

  modport slave (
    input  mem_address, mem_access_size, mem_rw, mem_enable,
    input  insn_valid, insn, insn_pc, fetch_fault,
    output mem_data_out, insn_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-aligned PC stream, single-word reads, PC-tagged FIFO
// toward decode, redirect flush. Optional bounds check enabled by FETCH_BOUNDS_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] START_ADDR = 32'h80020000,
  parameter int          MEM_DEPTH  = 1048576,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_unit_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MEM_DEPTH < 4) begin : g_param_err
      $error("fetch_unit: FIFO_DEPTH must be a power of two >= 2 and MEM_DEPTH >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic               resp_valid_reg;
  logic [31:0]        resp_pc_reg;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [31:0]        data_mem [FIFO_DEPTH];
  logic [31:0]        pc_mem   [FIFO_DEPTH];

  logic               issue, flush, push, pop, insn_valid, credit_ok, out_of_bounds;
  logic [CNT_W:0]     occupancy;
  logic [31:0]        redirect_aligned;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [32:0] LO_ADDR = {1'b0, START_ADDR};
  localparam logic [32:0] HI_ADDR = {1'b0, START_ADDR} + 33'(MEM_DEPTH) - 33'd4;
  assign out_of_bounds = ({1'b0, pc_reg} < LO_ADDR) || ({1'b0, pc_reg} > HI_ADDR);
  // HALT is only ever entered on a fault and is left only by reset, so it is the sticky flag.
  assign bus.fetch_fault = (state_reg == ST_HALT);
`else
  assign out_of_bounds   = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif

  // Credit counts buffered words plus the response arriving this cycle; pops give no credit.
  assign occupancy  = {1'b0, count_reg} + {{CNT_W{1'b0}}, resp_valid_reg};
  assign credit_ok  = occupancy < DEPTH_OCC;
  assign insn_valid = (count_reg != '0);
  assign push       = resp_valid_reg && !flush;
  assign pop        = insn_valid && bus.insn_ready && !flush;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    issue      = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_next = redirect_aligned;
        end
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_next = redirect_aligned;
        end else if (out_of_bounds) begin
          state_next = ST_HALT;
        end else if (credit_ok) begin
          issue   = 1'b1;
          pc_next = pc_reg + 32'd4;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= START_ADDR;
      resp_valid_reg <= 1'b0;
      resp_pc_reg    <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      resp_valid_reg <= issue;
      if (issue) resp_pc_reg <= pc_reg;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= bus.mem_data_out;
      pc_mem[wr_ptr_reg]   <= resp_pc_reg;
    end
  end

  assign bus.mem_address     = pc_reg;
  assign bus.mem_access_size = 2'b00;
  assign bus.mem_rw          = 1'b1;
  assign bus.mem_enable      = issue;
  assign bus.insn_valid      = insn_valid;
  // Stale storage is masked so an empty buffer always presents zeros.
  assign bus.insn            = insn_valid ? data_mem[rd_ptr_reg] : '0;
  assign bus.insn_pc         = insn_valid ? pc_mem[rd_ptr_reg] : '0;

endmodule
